mul_share_sched: RTL and testbench

- Shares one pipelined 16x16 multiplier (mul_en_in/mul_a/mul_b in, mul_en_out/mul_out back after fixed LAT cycles) between NREQ requesters.
- Round-robin issue, at most one operation in flight per requester.
- A tag pipeline tracks which requester owns each in-flight operation, and each result is returned on that requester's response channel.
- Sits between the multiplier instance and its client blocks.

---
 rtl/mul_share_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 64 ++++++
 rtl/mul_share_sched.sv | 199 +++++++++++++++++++
 tb/tb_mul_share_sched.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul_share_pkg.sv
// Shared definitions for the multiplier-sharing scheduler.
// Holds the per-requester state encoding, the datapath widths,
// the default NREQ/LAT values and the helper that sizes requester ids.
package mul_share_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } req_state_e;

  localparam int OPW      = 16;  // operand width
  localparam int PRODW    = 32;  // product width
  localparam int DEF_NREQ = 4;
  localparam int DEF_LAT  = 4;

  // Bits needed to name one of n requesters; never less than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (pointer -> 0)
//   elig_i    : per-index eligible vector
//   take_i    : the current grant is consumed this cycle (advances pointer)
//   grant_o   : one-hot (or zero) grant, first eligible index at or above
//               the pointer, wrapping modulo N
module rr_arbiter
  import mul_share_pkg::*;
#(
  parameter int N = DEF_NREQ
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] elig_i,
  input  logic         take_i,
  output logic [N-1:0] grant_o
);

  localparam int IW = id_width(N);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] win;
  logic          found;

  // First pass covers indices at or above the pointer, second pass wraps
  // around to the low indices.
  always_comb begin
    grant_o = '0;
    win     = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && elig_i[i] && (IW'(i) >= ptr_q)) begin
        grant_o[i] = 1'b1;
        win        = IW'(i);
        found      = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && elig_i[i]) begin
        grant_o[i] = 1'b1;
        win        = IW'(i);
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (take_i && found) begin
      ptr_d = (win == IW'(N - 1)) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mul_share_sched.sv
// Shares one pipelined multiplier (fixed latency LAT) between NREQ requesters.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/ready/a/b   : per-requester operation channel (a,b packed 16b each)
//   rsp_valid/ready/data  : per-requester result channel (data packed 32b each)
//   mul_en_in, mul_a/b    : registered issue to the multiplier
//   mul_en_out, mul_out   : multiplier result strobe and product
//   err                   : sticky flag for tag/strobe mismatches
//   idle                  : nothing pending anywhere
module mul_share_sched
  import mul_share_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int LAT  = DEF_LAT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [OPW*NREQ-1:0]   req_a,
  input  logic [OPW*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [PRODW*NREQ-1:0] rsp_data,
  output logic                  mul_en_in,
  output logic [OPW-1:0]        mul_a,
  output logic [OPW-1:0]        mul_b,
  input  logic                  mul_en_out,
  input  logic [PRODW-1:0]      mul_out,
  output logic                  err,
  output logic                  idle
);

  localparam int IDW = id_width(NREQ);
  localparam int DRW = $clog2(LAT + 2);

  req_state_e       state_q [NREQ];
  req_state_e       state_d [NREQ];
  logic [PRODW-1:0] rsp_data_q [NREQ];
  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  grant;

  logic             mul_en_in_q;
  logic [OPW-1:0]   mul_a_q;
  logic [OPW-1:0]   mul_b_q;
  logic [IDW-1:0]   issue_id_q;

  logic [LAT-1:0]   tag_vld_q;
  logic [IDW-1:0]   tag_id_q [LAT];
  logic [DRW-1:0]   drain_q;
  logic             err_q;

  logic [IDW-1:0]   win_id;
  logic [OPW-1:0]   win_a;
  logic [OPW-1:0]   win_b;
  logic             head_vld;
  logic [IDW-1:0]   head_id;
  logic             in_flight;
  logic             all_idle;

  // ---------------- arbitration ----------------
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_elig
    assign elig[gi] = req_valid[gi] & (state_q[gi] == ST_IDLE);
  end

  // Eligibility already includes req_valid, so any grant is a handshake.
  rr_arbiter #(.N(NREQ)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .elig_i (elig),
    .take_i (|grant),
    .grant_o(grant)
  );

  assign req_ready = grant;

  always_comb begin
    win_id = '0;
    win_a  = '0;
    win_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win_id = IDW'(i);
        win_a  = req_a[OPW*i +: OPW];
        win_b  = req_b[OPW*i +: OPW];
      end
    end
  end

  // ---------------- issue register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_en_in_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      issue_id_q  <= '0;
    end else begin
      mul_en_in_q <= |grant;
      if (|grant) begin
        mul_a_q    <= win_a;
        mul_b_q    <= win_b;
        issue_id_q <= win_id;
      end
    end
  end

  assign mul_en_in = mul_en_in_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;

  // ---------------- tag pipe ----------------
  // Fed from the issue register so the head lines up with mul_en_out,
  // LAT cycles after mul_en_in.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= '0;
      for (int k = 0; k < LAT; k++) tag_id_q[k] <= '0;
    end else begin
      tag_vld_q[0] <= mul_en_in_q;
      tag_id_q[0]  <= issue_id_q;
      for (int k = 1; k < LAT; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_id_q[k]  <= tag_id_q[k-1];
      end
    end
  end

  assign head_vld  = tag_vld_q[LAT-1];
  assign head_id   = tag_id_q[LAT-1];
  assign in_flight = mul_en_in_q | (|tag_vld_q);

  // ---------------- requester state machines ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) state_q[i] <= ST_IDLE;
    end else begin
      for (int i = 0; i < NREQ; i++) state_q[i] <= state_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      state_d[i] = state_q[i];
      unique case (state_q[i])
        ST_IDLE: if (grant[i]) state_d[i] = ST_BUSY;
        // A missing strobe frees the requester without a response.
        ST_BUSY: if (head_vld && head_id == IDW'(i))
                   state_d[i] = mul_en_out ? ST_DONE : ST_IDLE;
        ST_DONE: if (rsp_ready[i]) state_d[i] = ST_IDLE;
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rsp
    assign rsp_valid[gi]                  = (state_q[gi] == ST_DONE);
    assign rsp_data[PRODW*gi +: PRODW]    = rsp_data_q[gi];
  end

  // Result data only changes on capture, so it stays put while DONE waits.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) rsp_data_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (head_vld && mul_en_out && head_id == IDW'(i)) rsp_data_q[i] <= mul_out;
      end
    end
  end

  // ---------------- error / drain ----------------
  // drain_q counts cycles in which a strobe from an operation discarded by
  // reset may still arrive. It is only armed when something was actually in
  // flight, so a quiet reset leaves the block idle immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
      if (in_flight)            drain_q <= DRW'(LAT + 1);
      else if (drain_q != '0)   drain_q <= drain_q - 1'b1;
      else                      drain_q <= '0;
    end else begin
      if (drain_q != '0) drain_q <= drain_q - 1'b1;
      if ((head_vld && !mul_en_out) || (mul_en_out && !head_vld && drain_q == '0))
        err_q <= 1'b1;
    end
  end

  assign err = err_q;

  always_comb begin
    all_idle = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (state_q[i] != ST_IDLE) all_idle = 1'b0;
    end
  end

  assign idle = all_idle & ~(|tag_vld_q) & (drain_q == '0);

endmodule

// File: tb/tb_mul_share_sched.sv
module tb_mul_share_sched;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req_valid;
  logic [3:0]    req_ready;
  logic [63:0]   req_a;
  logic [63:0]   req_b;
  logic [3:0]    rsp_valid;
  logic [3:0]    rsp_ready;
  logic [127:0]  rsp_data;
  logic          mul_en_in;
  logic [15:0]   mul_a;
  logic [15:0]   mul_b;
  logic          mul_en_out;
  logic [31:0]   mul_out;
  logic          err;
  logic          idle;

  int total = 0;
  int bad   = 0;

  // bench multiplier model, latency 4, with fault-injection knobs
  logic [3:0]    pv = '0;
  logic [31:0]   pp [4];
  logic          kill;
  logic          inject;

  always #5 clk = ~clk;

  mul_share_sched #(.NREQ(4), .LAT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .mul_en_in (mul_en_in),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_en_out(mul_en_out),
    .mul_out   (mul_out),
    .err       (err),
    .idle      (idle)
  );

  always @(posedge clk) begin
    pv    <= {pv[2:0], mul_en_in};
    pp[0] <= {16'd0, mul_a} * {16'd0, mul_b};
    pp[1] <= pp[0];
    pp[2] <= pp[1];
    pp[3] <= pp[2];
  end

  assign mul_en_out = (pv[3] & ~kill) | inject;
  assign mul_out    = inject ? 32'hDEAD_BEEF : pp[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic setop(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  function automatic logic [31:0] rd(input int i);
    return rsp_data[32*i +: 32];
  endfunction

  int served [4];

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    rsp_ready = 4'hF; kill = 1'b0; inject = 1'b0;
    for (int i = 0; i < 4; i++) served[i] = 0;
    ticks(3);
    chk("rst_mul_en_in", mul_en_in, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data0", rd(0), 0);
    chk("rst_err", err, 0);
    chk("rst_idle", idle, 1);
    rst = 1'b0;
    tick();
    chk("post_rst_idle", idle, 1);

    // ---- single op: 3*5 ----
    req_valid = 4'b0001; setop(0, 16'd3, 16'd5); #1;
    chk("single_ready", req_ready, 4'b0001);
    tick(); req_valid = '0; #1;
    chk("single_en_in", mul_en_in, 1);
    chk("single_mul_a", mul_a, 3);
    chk("single_mul_b", mul_b, 5);
    ticks(4);
    chk("single_early", rsp_valid, 0);
    tick();
    chk("single_valid", rsp_valid, 4'b0001);
    chk("single_data", rd(0), 15);
    tick();
    chk("single_accepted", rsp_valid, 0);

    // reset so the pointer starts at 0 again
    rst = 1'b1; tick(); rst = 1'b0; tick();
    chk("rst2_idle", idle, 1);

    // ---- round robin ----
    rsp_ready = 4'h0; req_valid = 4'hF;
    for (int i = 0; i < 4; i++) setop(i, 16'(i + 1), 16'd10);
    #1;
    chk("rr_grant0", req_ready, 4'b0001);
    tick(); chk("rr_grant1", req_ready, 4'b0010);
    tick(); chk("rr_grant2", req_ready, 4'b0100);
    tick(); chk("rr_grant3", req_ready, 4'b1000);
    tick(); chk("rr_none", req_ready, 4'b0000);
    tick(); chk("rr_early", rsp_valid, 0);
    tick(); chk("rr_v6", rsp_valid, 4'b0001); chk("rr_d0", rd(0), 10);
    tick(); chk("rr_v7", rsp_valid, 4'b0011); chk("rr_d1", rd(1), 20);
    tick(); chk("rr_v8", rsp_valid, 4'b0111); chk("rr_d2", rd(2), 30);
    tick(); chk("rr_v9", rsp_valid, 4'b1111); chk("rr_d3", rd(3), 40);
    chk("rr_no_regrant", req_ready, 0);
    tick(); rsp_ready = 4'b0001; #1;
    chk("rr_accept_cycle_ready", req_ready, 0);
    tick(); #1;
    chk("rr_regrant0", req_ready, 4'b0001);
    chk("rr_v11", rsp_valid, 4'b1110);
    req_valid = '0; rsp_ready = 4'hF;
    tick();
    chk("rr_drained", rsp_valid, 0);
    chk("rr_idle", idle, 1);

    // ---- extremes ----
    req_valid = 4'b0011; setop(0, 16'hFFFF, 16'hFFFF); setop(1, 16'h0000, 16'h1234); #1;
    chk("ext_grant0", req_ready, 4'b0001);
    tick(); req_valid = 4'b0010; #1;
    chk("ext_grant1", req_ready, 4'b0010);
    tick(); req_valid = '0;
    ticks(4);
    chk("ext_v0", rsp_valid, 4'b0001); chk("ext_max", rd(0), 32'hFFFE0001);
    tick();
    chk("ext_v1", rsp_valid, 4'b0010); chk("ext_zero", rd(1), 0);
    tick();
    chk("ext_done", rsp_valid, 0);

    // ---- backpressure on requester 2 ----
    rsp_ready = 4'b1011; req_valid = 4'b0100; setop(2, 16'd7, 16'd9); #1;
    chk("bp_grant2", req_ready, 4'b0100);
    tick();
    req_valid = 4'hF; setop(0, 16'd1, 16'd2); setop(1, 16'd2, 16'd2); setop(3, 16'd4, 16'd2); #1;
    for (int c = 1; c < 16; c++) begin
      chk("bp_ready2", req_ready[2], 0);
      if (c >= 6) begin
        chk("bp_valid2", rsp_valid[2], 1);
        chk("bp_data2", rd(2), 63);
      end
      if (rsp_valid[0]) begin served[0]++; chk("bp_data0", rd(0), 2); end
      if (rsp_valid[1]) begin served[1]++; chk("bp_data1", rd(1), 4); end
      if (rsp_valid[3]) begin served[3]++; chk("bp_data3", rd(3), 8); end
      tick(); #1;
    end
    chk("bp_served0", 32'(served[0] > 0), 1);
    chk("bp_served1", 32'(served[1] > 0), 1);
    chk("bp_served3", 32'(served[3] > 0), 1);
    req_valid = '0; rsp_ready = 4'hF;
    for (int n = 0; n < 30 && !idle; n++) tick();
    chk("bp_idle", idle, 1);
    chk("bp_rsp_clear", rsp_valid, 0);

    // ---- mismatches ----
    chk("err_before", err, 0);
    inject = 1'b1; tick(); inject = 1'b0; #1;
    chk("err_orphan", err, 1);
    chk("err_orphan_rsp", rsp_valid, 0);
    req_valid = 4'b0010; setop(1, 16'd6, 16'd7); #1;
    chk("miss_grant1", req_ready, 4'b0010);
    tick(); req_valid = '0; kill = 1'b1;
    ticks(5); kill = 1'b0; #1;
    chk("miss_no_rsp", rsp_valid, 0);
    chk("miss_err_sticky", err, 1);
    req_valid = 4'b0010; #1;
    chk("miss_req1_idle", req_ready, 4'b0010);
    req_valid = '0;
    tick();
    chk("miss_idle", idle, 1);

    // ---- reset mid-flight ----
    req_valid = 4'b0111;
    setop(0, 16'd1, 16'd3); setop(1, 16'd2, 16'd3); setop(2, 16'd3, 16'd3); #1;
    chk("rmf_g0", req_ready, 4'b0100);
    tick(); chk("rmf_g1", req_ready, 4'b0001);
    tick(); chk("rmf_g2", req_ready, 4'b0010);
    tick(); req_valid = '0;
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; #1;
    for (int k = 0; k < 10; k++) begin
      chk("rmf_no_rsp", rsp_valid, 0);
      chk("rmf_err", err, 0);
      if (k == 5) chk("rmf_idle", idle, 1);
      tick();
    end
    req_valid = 4'b1000; setop(3, 16'd2, 16'd21); #1;
    chk("rmf_new_grant", req_ready, 4'b1000);
    tick(); req_valid = '0;
    ticks(5);
    chk("rmf_new_valid", rsp_valid, 4'b1000);
    chk("rmf_new_data", rd(3), 42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
